// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Purpose  : Execute-stage ALU; single-cycle logic/arith/shift ops, iterative
//            signed MULT (and DIV when ALU_EXEC_DIV_EN is defined) into HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_cntrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic             illegal
);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_NOR  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_MULT = 4'd9;
  localparam logic [3:0] OP_SLL  = 4'd10;
  localparam logic [3:0] OP_SRL  = 4'd13;
`ifdef ALU_EXEC_DIV_EN
  localparam logic [3:0] OP_DIV  = 4'd14;
`endif
  localparam logic [3:0] OP_SRA  = 4'd15;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
`ifdef ALU_EXEC_DIV_EN
  localparam logic [1:0] S_DIV  = 2'd2;
`endif
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic [1:0]         state;
  logic [1:0]         next_state;
  logic               accept;
  logic               start_mul;
  logic               start_div;

  logic [WIDTH-1:0]   simple_res;
  logic               op_illegal;
  logic               op_mul;
  logic               op_div;
  logic               b_zero;

  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] work;      // MUL: {partial, multiplier}; DIV: {remainder, quotient}
  logic [WIDTH-1:0]   opnd;      // MUL: |multiplicand|; DIV: |divisor|
  logic               neg_res;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

`ifdef ALU_EXEC_DIV_EN
  logic               is_div;
  logic               neg_rem;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
`endif

  // ---------------------------------------------------------------- decode
  always_comb begin
    simple_res = '0;
    op_illegal = 1'b0;
    op_mul     = 1'b0;
    op_div     = 1'b0;
    case (alu_cntrl)
      OP_AND:  simple_res = a & b;
      OP_OR:   simple_res = a | b;
      OP_ADD:  simple_res = a + b;
      OP_NOR:  simple_res = ~(a | b);
      OP_XOR:  simple_res = a ^ b;
      OP_SUB:  simple_res = a - b;
      OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_MULT: op_mul     = 1'b1;
      OP_SLL:  simple_res = b << shamt;
      OP_SRL:  simple_res = b >> shamt;
`ifdef ALU_EXEC_DIV_EN
      OP_DIV:  op_div     = 1'b1;
`endif
      OP_SRA:  simple_res = $unsigned($signed(b) >>> shamt);
      default: op_illegal = 1'b1;
    endcase
  end

  assign b_zero = (b == '0);
  assign abs_a  = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign abs_b  = b[WIDTH-1] ? (~b + 1'b1) : b;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start_mul)
          next_state = S_MUL;
`ifdef ALU_EXEC_DIV_EN
        else if (start_div)
          next_state = S_DIV;
`endif
      end
      S_MUL:   if (count == LAST) next_state = S_FIX;
`ifdef ALU_EXEC_DIV_EN
      S_DIV:   if (count == LAST) next_state = S_FIX;
`endif
      S_FIX:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    accept    = in_valid && in_ready;
    start_mul = accept && op_mul;
    start_div = accept && op_div && !b_zero;
  end

  // ---------------------------------------------------------------- iteration datapath
  // Shift-add: add |multiplicand| to the upper half when the multiplier LSB is set,
  // then shift the whole {carry, partial, multiplier} right by one.
  assign mul_sum  = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opnd} : '0);
  assign mul_next = {mul_sum, work[WIDTH-1:1]};
  assign prod_fix = neg_res ? (~work + 1'b1) : work;

`ifdef ALU_EXEC_DIV_EN
  // Restoring division: remainder < divisor holds every step, so the trial fits WIDTH+1 bits.
  assign div_shift = work[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_next  = div_diff[WIDTH]
                   ? {div_shift[WIDTH-1:0], work[WIDTH-2:0], 1'b0}
                   : {div_diff[WIDTH-1:0],  work[WIDTH-2:0], 1'b1};
  assign quo_fix   = neg_res ? (~work[WIDTH-1:0] + 1'b1) : work[WIDTH-1:0];
  assign rem_fix   = neg_rem ? (~work[2*WIDTH-1:WIDTH] + 1'b1) : work[2*WIDTH-1:WIDTH];
  assign fix_hi    = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign fix_lo    = is_div ? quo_fix : prod_fix[WIDTH-1:0];
`else
  assign fix_hi    = prod_fix[2*WIDTH-1:WIDTH];
  assign fix_lo    = prod_fix[WIDTH-1:0];
`endif

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      result      <= '0;
      zero        <= 1'b1;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
      illegal     <= 1'b0;
      count       <= '0;
      work        <= '0;
      opnd        <= '0;
      neg_res     <= 1'b0;
`ifdef ALU_EXEC_DIV_EN
      is_div      <= 1'b0;
      neg_rem     <= 1'b0;
`endif
    end else begin
      out_valid   <= 1'b0;
      div_by_zero <= 1'b0;
      illegal     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_mul) begin
            count   <= '0;
            opnd    <= abs_a;
            work    <= {{WIDTH{1'b0}}, abs_b};
            neg_res <= a[WIDTH-1] ^ b[WIDTH-1];
`ifdef ALU_EXEC_DIV_EN
            is_div  <= 1'b0;
`endif
          end
`ifdef ALU_EXEC_DIV_EN
          else if (start_div) begin
            count   <= '0;
            opnd    <= abs_b;
            work    <= {{WIDTH{1'b0}}, abs_a};
            neg_res <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_rem <= a[WIDTH-1];
            is_div  <= 1'b1;
          end
`endif
          else if (accept) begin
            // Simple, illegal and divide-by-zero requests all complete here.
            result      <= simple_res;
            zero        <= (simple_res == '0);
            out_valid   <= 1'b1;
            illegal     <= op_illegal;
            div_by_zero <= op_div && b_zero;
          end
        end
        S_MUL: begin
          work  <= mul_next;
          count <= count + 1'b1;
        end
`ifdef ALU_EXEC_DIV_EN
        S_DIV: begin
          work  <= div_next;
          count <= count + 1'b1;
        end
`endif
        S_FIX: begin
          hi        <= fix_hi;
          lo        <= fix_lo;
          result    <= fix_lo;
          zero      <= (fix_lo == '0);
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Purpose  : Randomized self-checking bench for alu_exec_unit against a
//            plain-arithmetic reference model (honours ALU_EXEC_DIV_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       alu_cntrl = '0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [4:0]       shamt = '0;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;
  logic             illegal;

  int errors = 0;
  int checks = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  alu_exec_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_cntrl(alu_cntrl), .a(a), .b(b), .shamt(shamt),
    .out_valid(out_valid), .result(result), .zero(zero), .hi(hi), .lo(lo),
    .div_by_zero(div_by_zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Architectural model: result, flags, latency, and HI/LO updates.
  task automatic model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] sh, output logic [31:0] r, output logic ill,
                       output logic dbz, output int lat);
    longint p, q, m;
    r = '0; ill = 1'b0; dbz = 1'b0; lat = 1;
    case (op)
      4'd0:  r = x & y;
      4'd1:  r = x | y;
      4'd2:  r = x + y;
      4'd3:  r = ~(x | y);
      4'd4:  r = x ^ y;
      4'd6:  r = x - y;
      4'd7:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd9: begin
        p = longint'($signed(x)) * longint'($signed(y));
        mhi = p[63:32]; mlo = p[31:0]; r = mlo; lat = WIDTH + 2;
      end
      4'd10: r = y << sh;
      4'd13: r = y >> sh;
      4'd15: r = $signed(y) >>> sh;
`ifdef ALU_EXEC_DIV_EN
      4'd14: begin
        if (y == 0) dbz = 1'b1;
        else begin
          q = longint'($signed(x)) / longint'($signed(y));
          m = longint'($signed(x)) % longint'($signed(y));
          mlo = q[31:0]; mhi = m[31:0]; r = mlo; lat = WIDTH + 2;
        end
      end
`endif
      default: ill = 1'b1;
    endcase
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic do_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] sh, input bit poke);
    logic [31:0] er;
    logic eill, edbz;
    int elat, lat;
    @(negedge clk);
    check("idle_ready", in_ready, 1);
    check("ov_pulse_low", out_valid, 0);
    alu_cntrl = op; a = x; b = y; shamt = sh; in_valid = 1'b1;
    model(op, x, y, sh, er, eill, edbz, elat);
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; shamt = 5'($urandom); alu_cntrl = 4'($urandom);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 60) begin
      if (elat > 1) check("busy_ready", in_ready, 0);
      if (poke) in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, elat);
    check("result", result, er);
    check("zero", zero, (er == 0));
    check("illegal", illegal, eill);
    check("div_by_zero", div_by_zero, edbz);
    check("hi", hi, mhi);
    check("lo", lo, mlo);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] er, x, y;
    logic eill, edbz;
    logic [3:0] op;
    logic [4:0] sh;
    int elat;
    bit seen;
    logic [3:0] simple_ops [11];
    simple_ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd10, 4'd13, 4'd15, 4'd5};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_illegal", illegal, 0);

    // Directed cases
    do_op(4'd2, 32'd7, 32'hFFFF_FFF9, 5'd0, 1'b0);
    check("add_wrap_zero", result, 32'h0);
    do_op(4'd15, 32'h0, 32'h8000_0000, 5'd4, 1'b0);
    check("sra_const", result, 32'hF800_0000);
    do_op(4'd13, 32'h0, 32'h8000_0000, 5'd4, 1'b0);
    check("srl_const", result, 32'h0800_0000);
    do_op(4'd7, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
    check("slt_const", result, 32'd1);
    do_op(4'd9, 32'hFFFF_FFFD, 32'h4000_0000, 5'd0, 1'b1);
    check("mult_hi_const", hi, 32'hFFFF_FFFF);
    check("mult_lo_const", lo, 32'h4000_0000);
    do_op(4'd14, 32'hFFFF_FFF9, 32'd2, 5'd0, 1'b1);
    do_op(4'd14, 32'd123, 32'd0, 5'd0, 1'b0);
    do_op(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b0);
    do_op(4'd12, 32'h1234, 32'h5678, 5'd0, 1'b0);

    // Back-to-back single-cycle ops, one accept per clock
    @(negedge clk);
    op = simple_ops[$urandom_range(0, 10)]; x = pick(); y = pick(); sh = 5'($urandom);
    alu_cntrl = op; a = x; b = y; shamt = sh; in_valid = 1'b1;
    model(op, x, y, sh, er, eill, edbz, elat);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("b2b_valid", out_valid, 1);
      check("b2b_result", result, er);
      check("b2b_illegal", illegal, eill);
      op = simple_ops[$urandom_range(0, 10)]; x = pick(); y = pick(); sh = 5'($urandom);
      alu_cntrl = op; a = x; b = y; shamt = sh;
      model(op, x, y, sh, er, eill, edbz, elat);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_last", result, er);

    // Reset in the middle of a MULT
    @(negedge clk);
    alu_cntrl = 4'd9; a = 32'hFFFF_FFFD; b = 32'h4000_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #2;
    check("midrst_ready", in_ready, 1);
    check("midrst_ov", out_valid, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    mhi = '0; mlo = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(4'd2, 32'd5, 32'd6, 5'd0, 1'b0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_stray_ov", seen, 0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      do_op(4'($urandom_range(0, 15)), pick(), pick(), 5'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
